hybrid_core_sched: RTL and testbench

HYBRID_CORE_SCHED -- requirements
Module: hybrid_core_sched

---
 rtl/hybrid_core_sched.sv | 169 ++++++++++++++++
 tb/tb_hybrid_core_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_core_sched.sv
// Two-requester round-robin scheduler in front of a fixed-latency transform core.
// Defining HYBRID_CORE_SCHED_STATS_EN adds the saturating job_count output.
module hybrid_core_sched #(
  parameter int CORE_LAT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [1:0]  req_mode0,
  input  logic [1:0]  req_mode1,
  input  logic [95:0] req_data0,
  input  logic [95:0] req_data1,
  output logic [1:0]  core_t_select,
  output logic [95:0] core_I,
  input  logic [95:0] core_rO,
  input  logic [95:0] core_iO,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [95:0] resp_re,
  output logic [95:0] resp_im,
  output logic        resp_id,
  output logic        resp_err
`ifdef HYBRID_CORE_SCHED_STATS_EN
  ,
  output logic [15:0] job_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [3:0] LastCnt = 4'(CORE_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  tsel_q, tsel_d;
  logic [95:0] coreI_q, coreI_d;
  logic [95:0] respRe_q, respRe_d;
  logic [95:0] respIm_q, respIm_d;
  logic        respId_q, respId_d;
  logic        respErr_q, respErr_d;
  logic        owner_q, owner_d;
  logic        errPend_q, errPend_d;
  logic        lastGrant_q, lastGrant_d;

  logic        pick1;
  logic        accept;
  logic        legal;
  logic [1:0]  selMode;
  logic [95:0] selData;

  // On a tie, requester 1 wins only if requester 0 was the previous owner.
  always_comb begin
    pick1      = req_valid1 && (!req_valid0 || !lastGrant_q);
    req_ready0 = (state_q == IDLE) && req_valid0 && !pick1;
    req_ready1 = (state_q == IDLE) && pick1;
    accept     = req_ready0 || req_ready1;
    selMode    = pick1 ? req_mode1 : req_mode0;
    selData    = pick1 ? req_data1 : req_data0;
    legal      = selMode[1] ^ selMode[0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tsel_d      = tsel_q;
    coreI_d     = coreI_q;
    respRe_d    = respRe_q;
    respIm_d    = respIm_q;
    respId_d    = respId_q;
    respErr_d   = respErr_q;
    owner_d     = owner_q;
    errPend_d   = errPend_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d   = pick1;
          cnt_d     = 4'd0;
          errPend_d = !legal;
          state_d   = BUSY;
          if (legal) begin
            tsel_d  = selMode;
            coreI_d = selData;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 4'd1;
        // An illegal job spends exactly one cycle here without touching the core.
        if (errPend_q) begin
          state_d   = RESP;
          respRe_d  = '0;
          respIm_d  = '0;
          respErr_d = 1'b1;
          respId_d  = owner_q;
        end else if (cnt_q == LastCnt) begin
          state_d   = RESP;
          respRe_d  = core_rO;
          respIm_d  = core_iO;
          respErr_d = 1'b0;
          respId_d  = owner_q;
          tsel_d    = 2'b00;
          coreI_d   = '0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d     = IDLE;
          lastGrant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      tsel_q      <= 2'b00;
      coreI_q     <= '0;
      respRe_q    <= '0;
      respIm_q    <= '0;
      respId_q    <= 1'b0;
      respErr_q   <= 1'b0;
      owner_q     <= 1'b0;
      errPend_q   <= 1'b0;
      lastGrant_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tsel_q      <= tsel_d;
      coreI_q     <= coreI_d;
      respRe_q    <= respRe_d;
      respIm_q    <= respIm_d;
      respId_q    <= respId_d;
      respErr_q   <= respErr_d;
      owner_q     <= owner_d;
      errPend_q   <= errPend_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign core_t_select = tsel_q;
  assign core_I        = coreI_q;
  assign resp_valid    = (state_q == RESP);
  assign resp_re       = respRe_q;
  assign resp_im       = respIm_q;
  assign resp_id       = respId_q;
  assign resp_err      = respErr_q;

`ifdef HYBRID_CORE_SCHED_STATS_EN
  logic [15:0] jobCnt_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      jobCnt_q <= 16'd0;
    end else if ((state_q == RESP) && resp_ready && (jobCnt_q != 16'hFFFF)) begin
      jobCnt_q <= jobCnt_q + 16'd1;
    end
  end

  assign job_count = jobCnt_q;
`endif

endmodule

// File: tb/tb_hybrid_core_sched.sv
// Self-checking bench for hybrid_core_sched: a cycle-stamped core stand-in plus a
// round-robin/latency reference model kept in plain task-level variables.
module tb_hybrid_core_sched;

  localparam int CORE_LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        req_valid0 = 1'b0;
  logic        req_valid1 = 1'b0;
  logic        req_ready0;
  logic        req_ready1;
  logic [1:0]  req_mode0 = 2'b00;
  logic [1:0]  req_mode1 = 2'b00;
  logic [95:0] req_data0 = '0;
  logic [95:0] req_data1 = '0;
  logic [1:0]  core_t_select;
  logic [95:0] core_I;
  logic [95:0] core_rO;
  logic [95:0] core_iO;
  logic        resp_valid;
  logic        respReady = 1'b0;
  logic [95:0] resp_re;
  logic [95:0] resp_im;
  logic        resp_id;
  logic        resp_err;
`ifdef HYBRID_CORE_SCHED_STATS_EN
  logic [15:0] job_count;
`endif

  int nChecks = 0;
  int nFails = 0;
  int lastOwner = 1;
  int expJobs = 0;

  hybrid_core_sched #(.CORE_LAT(CORE_LAT)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .req_valid0(req_valid0),
    .req_valid1(req_valid1),
    .req_ready0(req_ready0),
    .req_ready1(req_ready1),
    .req_mode0(req_mode0),
    .req_mode1(req_mode1),
    .req_data0(req_data0),
    .req_data1(req_data1),
    .core_t_select(core_t_select),
    .core_I(core_I),
    .core_rO(core_rO),
    .core_iO(core_iO),
    .resp_valid(resp_valid),
    .resp_ready(respReady),
    .resp_re(resp_re),
    .resp_im(resp_im),
    .resp_id(resp_id),
    .resp_err(resp_err)
`ifdef HYBRID_CORE_SCHED_STATS_EN
    ,
    .job_count(job_count)
`endif
  );

  always #5 CLK = ~CLK;

  // The core stand-in mixes in a free-running cycle stamp so a capture on the wrong edge shows up.
  logic [9:0] cyc = '0;
  always @(posedge CLK) cyc <= cyc + 10'd1;

  function automatic logic [95:0] coreRe(input logic [95:0] din, input logic [1:0] sel, input logic [9:0] stamp);
    return din ^ {8{sel, stamp}};
  endfunction

  function automatic logic [95:0] coreIm(input logic [95:0] din, input logic [1:0] sel, input logic [9:0] stamp);
    return {din[47:0], din[95:48]} + {8{~sel, stamp}};
  endfunction

  assign core_rO = coreRe(core_I, core_t_select, cyc);
  assign core_iO = coreIm(core_I, core_t_select, cyc);

  task automatic applyStimulus(input int who, input logic v, input logic [1:0] m, input logic [95:0] d);
    if (who == 0) begin
      req_valid0 = v;
      req_mode0  = m;
      req_data0  = d;
    end else begin
      req_valid1 = v;
      req_mode1  = m;
      req_data1  = d;
    end
  endtask

  task automatic resetDut();
    RESET = 1'b0;
    respReady = 1'b0;
    applyStimulus(0, 1'b0, 2'b00, '0);
    applyStimulus(1, 1'b0, 2'b00, '0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    lastOwner = 1;
    expJobs = 0;
  endtask

  // One complete job for requester 'who'; with bothValid the other requester stays valid throughout.
  task automatic runJob(input int who, input logic [1:0] mode, input logic [95:0] data,
                        input int stall, input bit bothValid, input logic [1:0] otherMode, input string tag);
    int other;
    int lat;
    bit legal;
    logic [9:0] acc;
    logic [95:0] expRe;
    logic [95:0] expIm;
    logic rWho;
    logic rOther;
    other = 1 - who;
    legal = (mode == 2'b01) || (mode == 2'b10);
    lat = legal ? CORE_LAT : 1;
    respReady = (stall == 0);
    applyStimulus(who, 1'b1, mode, data);
    applyStimulus(other, bothValid, otherMode, {$urandom, $urandom, $urandom});
    #1;
    rWho = (who == 0) ? req_ready0 : req_ready1;
    rOther = (who == 0) ? req_ready1 : req_ready0;
    nChecks++;
    if (rWho !== 1'b1 || rOther !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s grant: got ready0=%b ready1=%b, expected requester %0d only", tag, req_ready0, req_ready1, who);
    end
    acc = cyc;
    @(negedge CLK);
    if (!bothValid) applyStimulus(who, 1'b0, mode, data);
    for (int n = 0; n < lat; n++) begin
      #1;
      nChecks++;
      if (resp_valid !== 1'b0 || (req_ready0 | req_ready1) !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL %s busy_handshake c%0d: got resp_valid=%b readies=%b%b, expected 0 and 00", tag, n, resp_valid, req_ready0, req_ready1);
      end
      nChecks++;
      if (core_t_select !== (legal ? mode : 2'b00)) begin
        nFails++;
        $display("[TB] FAIL %s busy_tsel c%0d: got %b expected %b", tag, n, core_t_select, legal ? mode : 2'b00);
      end
      nChecks++;
      if (core_I !== (legal ? data : 96'd0)) begin
        nFails++;
        $display("[TB] FAIL %s busy_coreI c%0d: got %h expected %h", tag, n, core_I, legal ? data : 96'd0);
      end
      @(negedge CLK);
    end
    #1;
    expRe = legal ? coreRe(data, mode, acc + 10'(lat)) : 96'd0;
    expIm = legal ? coreIm(data, mode, acc + 10'(lat)) : 96'd0;
    nChecks++;
    if (resp_valid !== 1'b1 || resp_id !== 1'(who) || resp_err !== !legal) begin
      nFails++;
      $display("[TB] FAIL %s resp_flags: got valid=%b id=%b err=%b, expected 1 %0d %b", tag, resp_valid, resp_id, resp_err, who, !legal);
    end
    nChecks++;
    if (resp_re !== expRe || resp_im !== expIm) begin
      nFails++;
      $display("[TB] FAIL %s resp_data: got re=%h im=%h, expected re=%h im=%h", tag, resp_re, resp_im, expRe, expIm);
    end
    nChecks++;
    if (core_t_select !== 2'b00 || core_I !== 96'd0 || (req_ready0 | req_ready1) !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s resp_idle_core: got tsel=%b coreI=%h readies=%b%b, expected 00, 0, 00", tag, core_t_select, core_I, req_ready0, req_ready1);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      #1;
      nChecks++;
      if (resp_valid !== 1'b1 || resp_re !== expRe || resp_im !== expIm || resp_id !== 1'(who) || resp_err !== !legal || (req_ready0 | req_ready1) !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL %s stall_hold s%0d: got valid=%b id=%b err=%b readies=%b%b re=%h, expected 1 %0d %b 00 re=%h", tag, s, resp_valid, resp_id, resp_err, req_ready0, req_ready1, resp_re, who, !legal, expRe);
      end
    end
    respReady = 1'b1;
    @(negedge CLK);
    #1;
    lastOwner = who;
    if (expJobs < 65535) expJobs++;
    nChecks++;
    if (resp_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s release: got resp_valid=%b expected 0", tag, resp_valid);
    end
    rWho = (who == 0) ? req_ready0 : req_ready1;
    rOther = (who == 0) ? req_ready1 : req_ready0;
    nChecks++;
    if (rWho !== 1'b0 || rOther !== bothValid) begin
      nFails++;
      $display("[TB] FAIL %s next_grant: got owner_ready=%b other_ready=%b, expected 0 and %b", tag, rWho, rOther, bothValid);
    end
`ifdef HYBRID_CORE_SCHED_STATS_EN
    nChecks++;
    if (job_count !== 16'(expJobs)) begin
      nFails++;
      $display("[TB] FAIL %s job_count: got %0d expected %0d", tag, job_count, expJobs);
    end
`endif
  endtask

  task automatic test_reset();
    resetDut();
    #1;
    nChecks++;
    if (core_t_select !== 2'b00 || core_I !== 96'd0) begin
      nFails++;
      $display("[TB] FAIL reset_core: got tsel=%b coreI=%h expected 00 and 0", core_t_select, core_I);
    end
    nChecks++;
    if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_resp_flags: got valid=%b id=%b err=%b expected 0 0 0", resp_valid, resp_id, resp_err);
    end
    nChecks++;
    if (resp_re !== 96'd0 || resp_im !== 96'd0) begin
      nFails++;
      $display("[TB] FAIL reset_resp_data: got re=%h im=%h expected 0", resp_re, resp_im);
    end
`ifdef HYBRID_CORE_SCHED_STATS_EN
    nChecks++;
    if (job_count !== 16'd0) begin
      nFails++;
      $display("[TB] FAIL reset_job_count: got %0d expected 0", job_count);
    end
`endif
    applyStimulus(0, 1'b1, 2'b01, '0);
    applyStimulus(1, 1'b1, 2'b10, '0);
    #1;
    nChecks++;
    if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_first_tie: got ready0=%b ready1=%b expected 1 0", req_ready0, req_ready1);
    end
    applyStimulus(0, 1'b0, 2'b00, '0);
    applyStimulus(1, 1'b0, 2'b00, '0);
  endtask

  task automatic test_tie();
    int who;
    for (int k = 0; k < 4; k++) begin
      who = 1 - lastOwner;
      nChecks++;
      if (who !== (k % 2)) begin
        nFails++;
        $display("[TB] FAIL tie_order k%0d: model picks %0d expected %0d", k, who, k % 2);
      end
      runJob(who, (who == 0) ? 2'b01 : 2'b10, {$urandom, $urandom, $urandom}, 0, 1'b1,
             (who == 0) ? 2'b10 : 2'b01, "tie");
    end
    applyStimulus(0, 1'b0, 2'b00, '0);
    applyStimulus(1, 1'b0, 2'b00, '0);
  endtask

  task automatic test_single_job();
    runJob(0, 2'b01, {12'h001, 12'h80B, 12'h804, 12'h008, 12'h002, 12'h00F, 12'h807, 12'h803},
           0, 1'b0, 2'b00, "single");
  endtask

  task automatic test_illegal();
    runJob(1, 2'b11, {$urandom, $urandom, $urandom}, 0, 1'b0, 2'b00, "illegal11");
    runJob(0, 2'b00, {$urandom, $urandom, $urandom}, 1, 1'b0, 2'b00, "illegal00");
  endtask

  task automatic test_backpressure();
    runJob(1 - lastOwner, 2'b10, {$urandom, $urandom, $urandom}, 10, 1'b1, 2'b01, "backpressure");
    applyStimulus(0, 1'b0, 2'b00, '0);
    applyStimulus(1, 1'b0, 2'b00, '0);
  endtask

  task automatic test_reset_mid_job();
    applyStimulus(0, 1'b1, 2'b01, {$urandom, $urandom, $urandom});
    applyStimulus(1, 1'b0, 2'b00, '0);
    #1;
    nChecks++;
    if (req_ready0 !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL midreset_accept: got ready0=%b expected 1", req_ready0);
    end
    @(negedge CLK);
    applyStimulus(0, 1'b0, 2'b00, '0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    lastOwner = 1;
    expJobs = 0;
    #1;
    nChecks++;
    if (core_t_select !== 2'b00 || core_I !== 96'd0 || resp_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midreset_state: got tsel=%b coreI=%h valid=%b expected 00 0 0", core_t_select, core_I, resp_valid);
    end
    for (int c = 0; c < 2 * CORE_LAT; c++) begin
      @(negedge CLK);
      #1;
      nChecks++;
      if (resp_valid !== 1'b0 || core_t_select !== 2'b00) begin
        nFails++;
        $display("[TB] FAIL midreset_quiet c%0d: got valid=%b tsel=%b expected 0 00", c, resp_valid, core_t_select);
      end
    end
    applyStimulus(0, 1'b1, 2'b01, '0);
    applyStimulus(1, 1'b1, 2'b10, '0);
    #1;
    nChecks++;
    if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midreset_tie: got ready0=%b ready1=%b expected 1 0", req_ready0, req_ready1);
    end
    applyStimulus(0, 1'b0, 2'b00, '0);
    applyStimulus(1, 1'b0, 2'b00, '0);
  endtask

  task automatic test_random();
    int who;
    bit both;
    logic [1:0] mode;
    for (int k = 0; k < 24; k++) begin
      both = 1'($urandom_range(0, 1));
      who = both ? (1 - lastOwner) : int'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      runJob(who, mode, {$urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), both,
             2'($urandom_range(0, 3)), "random");
    end
    applyStimulus(0, 1'b0, 2'b00, '0);
    applyStimulus(1, 1'b0, 2'b00, '0);
  endtask

`ifdef HYBRID_CORE_SCHED_STATS_EN
  task automatic test_stats();
    resetDut();
    runJob(0, 2'b01, {$urandom, $urandom, $urandom}, 0, 1'b0, 2'b00, "stats_a");
    runJob(1, 2'b00, {$urandom, $urandom, $urandom}, 2, 1'b0, 2'b00, "stats_err");
    runJob(0, 2'b10, {$urandom, $urandom, $urandom}, 0, 1'b0, 2'b00, "stats_b");
    nChecks++;
    if (job_count !== 16'd3) begin
      nFails++;
      $display("[TB] FAIL stats_total: got %0d expected 3", job_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tie();
    test_single_job();
    test_illegal();
    test_backpressure();
    test_reset_mid_job();
    test_random();
`ifdef HYBRID_CORE_SCHED_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
